instr_fetch: RTL
================

Name: instr_fetch

Overview:
- Fetch stage feeding the opcode decoder of the 8-bit Harvard core.
- Sequences the PC and reads the synchronous instruction ROM.
- Latches each word into an instruction register and presents decoded fields (opcode, rd, rs1, rs2, imm) to decode/execute with a valid/ready handshake.
- Stops fetching permanently after issuing HLT (opcode 6'b111111) until reset.

Parameters:
- AW, 8: PC / instruction-memory address width.
- IW, 16: instruction width; field layout below assumes 16.
- HLT_OP, 6'b111111: opcode that terminates fetch.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- run  in  1  start fetching from IDLE.
- imem_rd  out  1  ROM read strobe.
- imem_addr  out  AW  ROM address.
- imem_data  in  IW  ROM data, valid the cycle after imem_rd.
- ir_valid  out  1  instruction fields valid.
- ir_ready  in  1  downstream accepts instruction.
- pc_out  out  AW  address of the instruction currently in IR.
- opcode  out  6  IR[15:10].
- rd  out  2  IR[9:8].
- rs1  out  2  IR[7:6].
- rs2  out  2  IR[5:4].
- imm  out  8  IR[7:0].
- halted  out  1  HLT has been issued.

Behaviour:
- Reset, sampled on clk edge only:
  - state=IDLE, pc=0, ir=0.
  - imem_rd=0, imem_addr=0, ir_valid=0, halted=0, pc_out=0.
  - All field outputs are therefore 0.
- State machine:
  - IDLE: outputs quiet. If run=1, go to REQ.
  - REQ: imem_rd=1, imem_addr=pc. Go to CAPT.
  - CAPT: ir<=imem_data, pc_out<=pc, pc<=pc+1 (mod 2^AW). Go to ISSUE.
  - ISSUE: ir_valid=1. On ir_ready=1: if opcode==HLT_OP go to HALT, else go to REQ. On ir_ready=0, hold all state.
  - HALT: ir_valid=0, halted=1, imem_rd=0. Stays here until rst.
- imem_addr is only meaningful while imem_rd=1; it holds its last value otherwise.
- Latency: run high in cycle 0 gives REQ in cycle 1, capture in cycle 2, ir_valid=1 in cycle 3.
  - With ir_ready tied high, throughput is 1 instruction per 3 cycles.
- Handshake:
  - The transfer completes on a clk edge where ir_valid&ir_ready=1.
  - While ir_valid=1 and ir_ready=0, ir, pc_out, all fields and pc are stable.
  - ir_ready is ignored outside ISSUE.
- run is sampled only in IDLE. Deasserting run afterwards has no effect.
- PC wrap: pc=2^AW-1 fetches that word, then pc becomes 0. No flag is raised and fetch continues.
- HLT is issued to downstream like any other instruction (ir_valid=1, opcode=111111) so decode can assert regprint. After acceptance, halted=1 on the next cycle.
- rst in any state, including mid-handshake or in HALT, returns to the reset values on that edge. A pending instruction is discarded.
- Unknown opcodes are passed through unchanged. Decoding is downstream's job.

Optional Feature:
- Macro: INSTR_FETCH_CNT_EN.
- When defined:
  - Adds output fetch_cnt [15:0], reset to 0.
  - Increments on every accepted transfer (ir_valid&ir_ready), including HLT.
  - Saturates at 16'hFFFF.
  - Frozen in HALT.
- When undefined: the port and counter do not exist. All other behaviour is identical.

Test Plan:
- Reset/start: assert rst 2 cycles, hold run=0 for 5 cycles -> imem_rd=0, ir_valid=0, halted=0. Set run=1 at cycle t -> imem_rd=1 with imem_addr=0 at t+1, ir_valid=1 at t+3.
- Field split: ROM[0]=16'h82A5 (mvi), ir_ready=1 -> opcode=6'b100000, rd=2, rs1=2, rs2=2, imm=8'hA5, pc_out=0.
- Back-pressure: ROM[0..2]=add,sub,xor. Hold ir_ready=0 for 4 cycles in ISSUE -> fields, pc_out=1 and ir_valid stay constant, no imem_rd. Release -> next imem_addr=2.
- Halt: ROM[3]=16'hFC00, ir_ready=1 -> HLT issued with pc_out=3, then halted=1, imem_rd never asserts again over 20 cycles. fetch_cnt=4 when INSTR_FETCH_CNT_EN is defined.
- Wrap: AW=8, ROM filled with non-HLT words, run 256+2 fetches -> imem_addr sequence 8'hFE, 8'hFF, 8'h00, 8'h01.
- Reset mid-operation: rst=1 while ir_valid=1 and ir_ready=0 -> next cycle ir_valid=0 and state IDLE. Restart with run=1 -> first imem_addr=0.

Source files
------------

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the 8-bit Harvard core.
//   Walks the PC through the synchronous instruction ROM. Each word is
//   latched into an instruction register, and its fields are offered
//   downstream under a valid/ready handshake. Fetch stops for good once
//   an HLT instruction has been accepted. Only reset restarts it.
// Ports:
//   clk, rst         clock (rising edge), synchronous active-high reset
//   run              start request, sampled only in IDLE
//   imem_rd/addr     ROM read strobe and address (addr held when rd=0)
//   imem_data        ROM word, valid the cycle after imem_rd
//   ir_valid/ready   handshake toward decode
//   pc_out           address of the word currently held in IR
//   opcode/rd/rs1/rs2/imm  decoded IR fields (imm overlaps rs1/rs2)
//   halted           set the cycle after HLT is accepted
// Optional build macro INSTR_FETCH_CNT_EN adds fetch_cnt[15:0]. This is a
// saturating count of accepted transfers, and it includes HLT.
module instr_fetch #(
  parameter int          AW     = 8,
  parameter int          IW     = 16,
  parameter logic [5:0]  HLT_OP = 6'b111111
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic          imem_rd,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_data,
  output logic          ir_valid,
  input  logic          ir_ready,
  output logic [AW-1:0] pc_out,
  output logic [5:0]    opcode,
  output logic [1:0]    rd,
  output logic [1:0]    rs1,
  output logic [1:0]    rs2,
  output logic [7:0]    imm,
  output logic          halted
`ifdef INSTR_FETCH_CNT_EN
  ,
  output logic [15:0]   fetch_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, REQ, CAPT, ISSUE, HALT} state_t;

  state_t        state;
  logic [AW-1:0] pc;
  logic [IW-1:0] ir;

  // Fields are combinational slices of a register, so they are stable
  // for as long as IR is held during back-pressure.
  assign opcode = ir[15:10];
  assign rd     = ir[9:8];
  assign rs1    = ir[7:6];
  assign rs2    = ir[5:4];
  assign imm    = ir[7:0];

  // The strobe and valid outputs are registered. Each one is set on the
  // edge that enters its state and cleared on the edge that leaves it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      pc        <= '0;
      ir        <= '0;
      imem_rd   <= 1'b0;
      imem_addr <= '0;
      ir_valid  <= 1'b0;
      halted    <= 1'b0;
      pc_out    <= '0;
    end else begin
      case (state)
        IDLE: if (run) begin
          state     <= REQ;
          imem_rd   <= 1'b1;
          imem_addr <= pc;
        end
        REQ: begin
          state   <= CAPT;
          imem_rd <= 1'b0;
        end
        CAPT: begin
          ir       <= imem_data;
          pc_out   <= pc;
          pc       <= pc + AW'(1);  // wraps silently at 2^AW
          ir_valid <= 1'b1;
          state    <= ISSUE;
        end
        ISSUE: if (ir_ready) begin
          ir_valid <= 1'b0;
          if (ir[15:10] == HLT_OP) begin
            state  <= HALT;
            halted <= 1'b1;
          end else begin
            state     <= REQ;
            imem_rd   <= 1'b1;
            imem_addr <= pc;
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef INSTR_FETCH_CNT_EN
  // Accepts can only happen in ISSUE, so the count freezes in HALT.
  always_ff @(posedge clk) begin
    if (rst)
      fetch_cnt <= '0;
    else if (state == ISSUE && ir_ready && fetch_cnt != 16'hFFFF)
      fetch_cnt <= fetch_cnt + 16'd1;
  end
`endif

endmodule
